// File: rtl/subleq_io_bridge.sv
// SUBLEQ CPU I/O bridge: routes CPU accesses to RAM or to a small
// memory-mapped I/O window at the top of the address space.
//
// Ports:
//   clk, areset (async, active-low)
//   cpu_load/cpu_addr/cpu_data_out  : CPU bus in
//   cpu_data_in/cpu_halt            : CPU bus out (read data, stall)
//   ext_halt                        : external halt, ORed into cpu_halt
//   mem_addr/mem_wdata/mem_we/mem_rdata : sync single-port RAM
//   out_valid/out_ready/out_data    : output stream (FIFO + skid)
//   in_valid/in_ready/in_data       : input stream (pop strobe)
//   stopped                         : sticky stop flag
//
// Address map (M = all ones):
//   M = STOP, M-1 = OUT, M-2 = IN, M-3 = STAT, below = RAM.
module subleq_io_bridge #(
   parameter int WORD_SIZE = 8,
   parameter int OUT_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 areset,
   input  logic                 cpu_load,
   input  logic [WORD_SIZE-1:0] cpu_addr,
   input  logic [WORD_SIZE-1:0] cpu_data_out,
   output logic [WORD_SIZE-1:0] cpu_data_in,
   output logic                 cpu_halt,
   input  logic                 ext_halt,
   output logic [WORD_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0] mem_wdata,
   output logic                 mem_we,
   input  logic [WORD_SIZE-1:0] mem_rdata,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_SIZE-1:0] out_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WORD_SIZE-1:0] in_data,
   output logic                 stopped
);

   localparam int AW = $clog2(OUT_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(OUT_DEPTH);

   localparam logic [WORD_SIZE-1:0] A_STOP = '1;
   localparam logic [WORD_SIZE-1:0] A_OUT  =
      {{(WORD_SIZE-1){1'b1}}, 1'b0};
   localparam logic [WORD_SIZE-1:0] A_IN   =
      {{(WORD_SIZE-2){1'b1}}, 2'b01};
   localparam logic [WORD_SIZE-1:0] A_STAT =
      {{(WORD_SIZE-2){1'b1}}, 2'b00};

   localparam logic [2:0] C_RAM  = 3'd0;
   localparam logic [2:0] C_STAT = 3'd1;
   localparam logic [2:0] C_IN   = 3'd2;
   localparam logic [2:0] C_OUT  = 3'd3;
   localparam logic [2:0] C_STOP = 3'd4;

   logic [2:0]           cls;
   logic [2:0]           rcls_q;
   logic [WORD_SIZE-1:0] io_q;
   logic [WORD_SIZE-1:0] io_d;
   logic [WORD_SIZE-1:0] status;

   logic [WORD_SIZE-1:0] fifo_mem [OUT_DEPTH];
   logic [AW-1:0]        wptr;
   logic [AW-1:0]        rptr;
   logic [AW:0]          count;
   logic                 full;
   logic                 pop;
   logic                 push_en;
   logic [WORD_SIZE-1:0] push_data;
   logic                 skid_load;
   logic                 pend_valid;
   logic [WORD_SIZE-1:0] pend_data;
   logic                 out_st;
   logic                 stop_st;

   // Address class decode
   always_comb begin
      cls = C_RAM;
      case (cpu_addr)
         A_STOP:  cls = C_STOP;
         A_OUT:   cls = C_OUT;
         A_IN:    cls = C_IN;
         A_STAT:  cls = C_STAT;
         default: cls = C_RAM;
      endcase
   end

   assign mem_addr  = cpu_addr;
   assign mem_wdata = cpu_data_out;
   assign mem_we    = !cpu_load && (cls == C_RAM) && !stopped;

   assign out_st  = !cpu_load && (cls == C_OUT) && !stopped;
   assign stop_st = !cpu_load && (cls == C_STOP);

   // Pop strobe is gated by reset so nothing is consumed
   // from the input stream while the bridge is held in reset.
   assign in_ready = areset && cpu_load && (cls == C_IN) && in_valid;

   assign full      = (count == DEPTH_C);
   assign out_valid = (count != '0);
   assign out_data  = fifo_mem[rptr];
   assign pop       = out_valid && out_ready;

   assign cpu_halt = ext_halt | pend_valid | stopped;

   assign status = {{(WORD_SIZE-4){1'b0}},
                    stopped, pend_valid, full, in_valid};

   // I/O read value captured at the access cycle
   always_comb begin
      io_d = '0;
      if (cpu_load) begin
         if (cls == C_IN && in_valid) begin
            io_d = in_data;
         end else if (cls == C_STAT) begin
            io_d = status;
         end
      end
   end

   // RAM data only reaches the CPU once out of reset; the
   // I/O register is cleared by reset, so the output reads 0.
   assign cpu_data_in = (rcls_q == C_RAM && areset) ? mem_rdata : io_q;

   // Skid entry always drains first, so ordering is kept.
   // A store arriving while the skid is occupied is dropped.
   always_comb begin
      push_en   = 1'b0;
      push_data = cpu_data_out;
      skid_load = 1'b0;
      if (pend_valid) begin
         if (!full || pop) begin
            push_en   = 1'b1;
            push_data = pend_data;
         end
      end else if (out_st) begin
         if (!full || pop) begin
            push_en = 1'b1;
         end else begin
            skid_load = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) begin
         fifo_mem[wptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_en) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         case ({push_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         pend_valid <= 1'b0;
         pend_data  <= '0;
      end else if (skid_load) begin
         pend_valid <= 1'b1;
         pend_data  <= cpu_data_out;
      end else if (pend_valid && push_en) begin
         pend_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         stopped <= 1'b0;
      end else if (stop_st) begin
         stopped <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         rcls_q <= C_RAM;
         io_q   <= '0;
      end else begin
         rcls_q <= cls;
         io_q   <= io_d;
      end
   end

endmodule

// File: tb/tb_subleq_io_bridge.sv
// Directed bench for subleq_io_bridge: RAM path, I/O window,
// output FIFO/skid back-pressure and sticky stop.
module tb_subleq_io_bridge;

   logic       clk;
   logic       areset;
   logic       cpu_load;
   logic [7:0] cpu_addr;
   logic [7:0] cpu_data_out;
   logic [7:0] cpu_data_in;
   logic       cpu_halt;
   logic       ext_halt;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_we;
   logic [7:0] mem_rdata;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       stopped;

   int total = 0;
   int bad   = 0;
   logic [7:0] out_q [$];

   subleq_io_bridge #(.WORD_SIZE(8), .OUT_DEPTH(4)) dut (
      .clk(clk), .areset(areset),
      .cpu_load(cpu_load), .cpu_addr(cpu_addr),
      .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in),
      .cpu_halt(cpu_halt), .ext_halt(ext_halt),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data),
      .stopped(stopped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; any handshake at this edge is scored.
   task automatic tick();
      logic [7:0] e;
      #1;
      if (out_valid && out_ready) begin
         if (out_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL pop_extra observed=%h expected=none", out_data);
         end else begin
            e = out_q.pop_front();
            chk8("pop", out_data, e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic park();
      cpu_load = 1'b1;
      cpu_addr = 8'hFF;
   endtask

   task automatic out_store(input logic [7:0] v, input logic accepted);
      cpu_load     = 1'b0;
      cpu_addr     = 8'hFE;
      cpu_data_out = v;
      if (accepted) out_q.push_back(v);
      tick();
   endtask

   initial begin
      areset       = 1'b0;
      cpu_load     = 1'b1;
      cpu_addr     = 8'h00;
      cpu_data_out = 8'h00;
      ext_halt     = 1'b0;
      mem_rdata    = 8'h00;
      out_ready    = 1'b0;
      in_valid     = 1'b0;
      in_data      = 8'h00;

      // reset with random inputs
      for (int i = 0; i < 4; i++) begin
         cpu_load     = 1'($urandom);
         cpu_addr     = 8'($urandom);
         cpu_data_out = 8'($urandom);
         ext_halt     = 1'($urandom);
         mem_rdata    = 8'($urandom);
         out_ready    = 1'($urandom);
         in_valid     = 1'($urandom);
         in_data      = 8'($urandom);
         #1;
         chk1("rst_out_valid", out_valid, 1'b0);
         chk1("rst_in_ready", in_ready, 1'b0);
         chk1("rst_halt", cpu_halt, ext_halt);
         chk8("rst_data_in", cpu_data_in, 8'h00);
         tick();
      end

      ext_halt  = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      park();
      #1;
      areset = 1'b1;
      tick();

      // RAM read, 1-cycle latency
      cpu_load = 1'b1;
      cpu_addr = 8'h10;
      tick();
      cpu_addr  = 8'h00;
      mem_rdata = 8'h5A;
      #1;
      chk8("ram_rd", cpu_data_in, 8'h5A);
      chk1("park_not_stopped", stopped, 1'b0);

      ext_halt = 1'b1;
      #1;
      chk1("ext_halt_pass", cpu_halt, 1'b1);
      ext_halt = 1'b0;

      // RAM store
      cpu_load     = 1'b0;
      cpu_addr     = 8'h20;
      cpu_data_out = 8'h33;
      #1;
      chk1("ram_we", mem_we, 1'b1);
      chk8("ram_waddr", mem_addr, 8'h20);
      chk8("ram_wdata", mem_wdata, 8'h33);
      tick();
      park();
      #1;
      chk1("ram_we_off", mem_we, 1'b0);

      // stores to IN/STAT ignored
      cpu_load = 1'b0;
      cpu_addr = 8'hFD;
      in_valid = 1'b1;
      #1;
      chk1("in_st_we", mem_we, 1'b0);
      chk1("in_st_ready", in_ready, 1'b0);
      tick();
      in_valid = 1'b0;
      cpu_addr = 8'hFC;
      #1;
      chk1("stat_st_we", mem_we, 1'b0);
      tick();
      cpu_load = 1'b1;
      cpu_addr = 8'hFC;
      tick();
      park();
      #1;
      chk8("stat_idle", cpu_data_in, 8'h00);

      // OUT back-pressure
      for (int v = 1; v <= 4; v++) out_store(8'(v), 1'b1);
      park();
      #1;
      chk1("full_halt", cpu_halt, 1'b0);
      chk1("full_valid", out_valid, 1'b1);
      chk8("full_head", out_data, 8'h01);
      cpu_addr = 8'hFC;
      tick();
      park();
      #1;
      chk8("stat_full", cpu_data_in, 8'h02);

      out_store(8'h05, 1'b1);
      park();
      #1;
      chk1("skid_halt", cpu_halt, 1'b1);
      out_store(8'h66, 1'b0);
      cpu_load = 1'b1;
      cpu_addr = 8'hFC;
      tick();
      park();
      #1;
      chk8("stat_skid", cpu_data_in, 8'h06);

      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      chk1("skid_drained", cpu_halt, 1'b0);
      chk8("head_after", out_data, 8'h02);

      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      out_ready = 1'b0;
      #1;
      chk1("drained_valid", out_valid, 1'b0);
      chk8("q_empty1", 8'(out_q.size()), 8'd0);

      // full with simultaneous pop
      for (int v = 8'h11; v <= 8'h14; v++) out_store(8'(v), 1'b1);
      out_ready = 1'b1;
      out_store(8'h77, 1'b1);
      out_ready = 1'b0;
      cpu_load  = 1'b1;
      cpu_addr  = 8'hFC;
      #1;
      chk1("sim_pop_halt", cpu_halt, 1'b0);
      tick();
      park();
      #1;
      chk8("sim_pop_stat", cpu_data_in, 8'h02);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      out_ready = 1'b0;
      #1;
      chk8("q_empty2", 8'(out_q.size()), 8'd0);

      // IN reads
      in_valid = 1'b1;
      in_data  = 8'h9C;
      cpu_load = 1'b1;
      cpu_addr = 8'hFD;
      #1;
      chk1("in_pop", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      in_data  = 8'hEE;
      #1;
      chk8("in_data", cpu_data_in, 8'h9C);
      chk1("in_nopop", in_ready, 1'b0);
      tick();
      park();
      #1;
      chk8("in_empty", cpu_data_in, 8'h00);

      // STOP
      out_store(8'h41, 1'b1);
      out_store(8'h42, 1'b1);
      out_store(8'h43, 1'b1);
      cpu_load = 1'b0;
      cpu_addr = 8'hFF;
      tick();
      park();
      #1;
      chk1("stopped", stopped, 1'b1);
      chk1("stop_halt", cpu_halt, 1'b1);
      cpu_load     = 1'b0;
      cpu_addr     = 8'h20;
      cpu_data_out = 8'hAA;
      #1;
      chk1("stop_we", mem_we, 1'b0);
      out_store(8'h99, 1'b0);
      park();
      out_ready = 1'b1;
      tick();
      tick();
      out_ready = 1'b0;
      #1;
      chk1("stop_still", stopped, 1'b1);
      chk8("stop_head", out_data, 8'h43);

      // reset mid-operation discards FIFO contents
      areset = 1'b0;
      #1;
      chk1("rst_stopped", stopped, 1'b0);
      chk1("rst_halt2", cpu_halt, 1'b0);
      chk1("rst_flush", out_valid, 1'b0);
      out_q.delete();
      tick();
      areset = 1'b1;
      tick();
      chk1("post_rst_valid", out_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/subleq_io_bridge.md
Name: subleq_io_bridge

Overview:
- Sits directly downstream of the SUBLEQ CPU. Consumes its load/addr/data_out bus and produces its data_in and halt inputs.
- Routes normal accesses to a synchronous single-port RAM.
- Decodes a small memory-mapped I/O window at the top of the address space:
  - an output stream backed by a FIFO and a one-entry skid register;
  - an input stream;
  - a status word;
  - a sticky stop address.
- Applies back-pressure to the CPU through cpu_halt.

Parameters:
- WORD_SIZE, 8, data and address width; matches the CPU word.
- OUT_DEPTH, 4, output FIFO depth; power of two, ≥2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-low reset.
- cpu_load  in  1  1 = read cycle, 0 = store cycle.
- cpu_addr  in  WORD_SIZE  CPU address.
- cpu_data_out  in  WORD_SIZE  CPU store data.
- cpu_data_in  out  WORD_SIZE  read data to CPU; registered, 1-cycle latency.
- cpu_halt  out  1  stall/stop request to CPU.
- ext_halt  in  1  external halt request; passed through.
- mem_addr  out  WORD_SIZE  RAM address; equals cpu_addr.
- mem_wdata  out  WORD_SIZE  RAM write data; equals cpu_data_out.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  WORD_SIZE  RAM read data, valid 1 cycle after mem_addr.
- out_valid  out  1  output stream valid.
- out_ready  in  1  output stream ready.
- out_data  out  WORD_SIZE  output stream data.
- in_valid  in  1  input stream valid.
- in_ready  out  1  input stream pop strobe.
- in_data  in  WORD_SIZE  input stream data.
- stopped  out  1  sticky stop flag.

Behaviour:
- Address map, with M = 2^WORD_SIZE − 1:
  - M: STOP
  - M−1: OUT
  - M−2: IN
  - M−3: STAT
  - all lower addresses: RAM
- Reset (areset low, async) clears:
  - FIFO count, read pointer and write pointer → 0.
  - Skid register (pend_valid) → 0.
  - stopped → 0.
  - Read-select register → RAM.
  - cpu_data_in → 0.
  - Consequently out_valid = 0 and in_ready = 0. cpu_halt = ext_halt.
- Reset mid-operation discards all FIFO and skid contents.
- RAM store: mem_we = !cpu_load && RAM address && !stopped. Combinational, same cycle.
- Reads:
  - The bridge registers the address class each cycle.
  - cpu_data_in is muxed from that registered class:
    - RAM class: mem_rdata (combinational from RAM output).
    - Any other class: a registered I/O value captured at the access cycle.
- IN read (cpu_load && addr = IN):
  - in_valid = 1: in_ready pulses 1 for that cycle (combinational), popping one item; next-cycle cpu_data_in = in_data.
  - in_valid = 0: no pop; next-cycle cpu_data_in = 0.
  - Reads are never blocking.
- STAT read: next-cycle cpu_data_in, zero-extended:
  - bit0 = in_valid
  - bit1 = FIFO full
  - bit2 = pend_valid
  - bit3 = stopped
- OUT or STOP read: returns 0.
- Writes to IN or STAT are ignored.
- OUT store (!cpu_load && addr = OUT && !stopped), always accepted in the cycle presented:
  - FIFO not full, or a pop happens in the same cycle: push cpu_data_out into the FIFO.
  - Otherwise: capture into the skid register; pend_valid = 1.
- Skid drain: while pend_valid, move the skid entry into the FIFO on the first cycle that count < OUT_DEPTH, or on a same-cycle pop. Clear pend_valid in that cycle.
- Skid full: a further OUT store while pend_valid = 1 is a protocol violation; data is dropped and state is unchanged.
- Output handshake:
  - out_valid = (count ≠ 0); out_data = head entry.
  - A pop occurs when out_valid && out_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo OUT_DEPTH.
- STOP store: sets stopped = 1 at the next edge; stays set until reset. The FIFO and skid keep draining while stopped.
- cpu_halt = ext_halt | pend_valid | stopped (combinational from registers plus ext_halt).
- While the CPU is halted it parks cpu_addr = M with cpu_load = 1. This is treated as a STOP read: no side effects, and stopped is not set.

Test Plan:
- Reset/idle: hold areset low with random inputs → out_valid=0, in_ready=0, cpu_halt=ext_halt, cpu_data_in=0. Release, read RAM addr 0x10 with mem_rdata=0x5A → cpu_data_in=0x5A one cycle later.
- RAM store: cpu_load=0, addr=0x20, data=0x33 → mem_we=1 for exactly that cycle. Store to 0xFD or 0xFC → mem_we=0 and no state change.
- OUT back-pressure (OUT_DEPTH=4, out_ready=0): stores 0x01..0x04 to 0xFE → FIFO full, cpu_halt=0. Fifth store 0x05 → pend_valid=1, cpu_halt=1. Raise out_ready for one cycle → 0x01 emitted, 0x05 enters the FIFO, cpu_halt=0 next cycle. Drain → sequence 0x02,0x03,0x04,0x05.
- Full + simultaneous pop: FIFO full, out_ready=1, store 0x77 in the same cycle → no skid, count stays 4, 0x77 is last out.
- IN read: in_valid=1, in_data=0x9C, read 0xFD → in_ready=1 for one cycle, cpu_data_in=0x9C next cycle. in_valid=0 → in_ready=0, cpu_data_in=0x00. Read 0xFC with FIFO full → 0x02.
- STOP: store to 0xFF → stopped=1, cpu_halt=1 thereafter. Later store to 0x20 → mem_we=0. Pending FIFO data still drains. areset low → stopped=0.
